// File: rtl/divider_pkg.sv
// Shared types for the fixed-point restoring divider.
package divider_pkg;

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    function automatic int cnt_width(input int qw);
        return $clog2(qw + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract D if it fits.
module div_step #(
    parameter int NI = 8
) (
    input  logic [NI:0]   r,
    input  logic          b,
    input  logic [NI-1:0] d,
    output logic [NI:0]   r_next,
    output logic          q_bit
);

    // R < D always holds, so 2R+b never needs more than NI+1 bits.
    assign q_bit  = ({r, b} >= {2'b00, d});
    assign r_next = q_bit ? (NI+1)'({r, b} - {2'b00, d}) : (NI+1)'({r, b});

endmodule

// File: rtl/fx_restoring_divider_pipe.sv
// Sequential restoring divider, Q = floor(X*2^NF / D) in NI.NF fixed point, one bit per cycle.
// Define DIVIDER_SIGNED_EN to add the in_signed port and the signed FIXUP cycle.
module fx_restoring_divider_pipe
    import divider_pkg::*;
#(
    parameter int NI = 8,
    parameter int NF = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NI-1:0]        dividend,
    input  logic [NI-1:0]        divisor,
`ifdef DIVIDER_SIGNED_EN
    input  logic                 in_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NI+NF-1:0]     quotient,
    output logic [NI-1:0]        remainder,
    output logic                 div_zero,
    output logic                 ovf
);

    localparam int QW = NI + NF;
    localparam int CW = cnt_width(QW);

    state_t          state_q, state_d;
    logic [NI-1:0]   x_q, x_d, d_q, d_d;
    logic [NI:0]     r_q, r_d, r_nx;
    logic [QW-1:0]   q_q, q_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic [NI-1:0]   rem_q, rem_d;
    logic            dz_q, dz_d, ovf_q, ovf_d;
    logic            q_bit;
`ifdef DIVIDER_SIGNED_EN
    localparam logic [QW-1:0] Q_MAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};
    logic            sgn_q, sgn_d, neg_q, neg_d, sx_q, sx_d;
    logic            sx_in, sd_in;
`endif

    div_step #(.NI(NI)) u_step (
        .r      (r_q),
        .b      (x_q[NI-1]),
        .d      (d_q),
        .r_next (r_nx),
        .q_bit  (q_bit)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        d_d     = d_q;
        r_d     = r_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ovf_d   = ovf_q;
`ifdef DIVIDER_SIGNED_EN
        sgn_d   = sgn_q;
        neg_d   = neg_q;
        sx_d    = sx_q;
        sx_in   = in_signed & dividend[NI-1];
        sd_in   = in_signed & divisor[NI-1];
`endif
        case (state_q)
            IDLE: if (in_valid) begin
`ifdef DIVIDER_SIGNED_EN
                x_d   = sx_in ? (~dividend + 1'b1) : dividend;
                d_d   = sd_in ? (~divisor + 1'b1) : divisor;
                sgn_d = in_signed;
                neg_d = sx_in ^ sd_in;
                sx_d  = sx_in;
`else
                x_d   = dividend;
                d_d   = divisor;
`endif
                if (divisor == '0) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rem_d   = dividend;
                    dz_d    = 1'b1;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = CALC;
                    r_d     = '0;
                    cnt_d   = '0;
                end
            end
            CALC: begin
                // Dividend bits leave from the MSB; quotient bits enter at the LSB.
                r_d   = r_nx;
                q_d   = {q_q[QW-2:0], q_bit};
                x_d   = x_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(QW - 1)) begin
`ifdef DIVIDER_SIGNED_EN
                    if (sgn_q) state_d = FIXUP;
                    else
`endif
                    begin
                        state_d = DONE;
                        quo_d   = {q_q[QW-2:0], q_bit};
                        rem_d   = r_nx[NI-1:0];
                        dz_d    = 1'b0;
                        ovf_d   = 1'b0;
                    end
                end
            end
`ifdef DIVIDER_SIGNED_EN
            FIXUP: begin
                state_d = DONE;
                dz_d    = 1'b0;
                rem_d   = sx_q ? (~r_q[NI-1:0] + 1'b1) : r_q[NI-1:0];
                if (!neg_q) begin
                    ovf_d = (q_q > Q_MAX);
                    quo_d = (q_q > Q_MAX) ? Q_MAX : q_q;
                end else begin
                    ovf_d = (q_q > Q_MIN);
                    quo_d = (q_q > Q_MIN) ? Q_MIN : (~q_q + 1'b1);
                end
            end
`endif
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            sgn_q   <= 1'b0;
            neg_q   <= 1'b0;
            sx_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            d_q     <= d_d;
            r_q     <= r_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ovf_q   <= ovf_d;
`ifdef DIVIDER_SIGNED_EN
            sgn_q   <= sgn_d;
            neg_q   <= neg_d;
            sx_q    <= sx_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fx_restoring_divider_pipe.sv
// Directed + random bench for fx_restoring_divider_pipe against an arithmetic reference model.
module tb_fx_restoring_divider_pipe;

    localparam int NI = 8;
    localparam int NF = 8;
    localparam int QW = NI + NF;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [NI-1:0] dividend = '0;
    logic [NI-1:0] divisor = '0;
    logic          in_signed = 1'b0;
    logic          in_ready, out_valid, div_zero, ovf;
    logic [QW-1:0] quotient;
    logic [NI-1:0] remainder;

    int total = 0;
    int bad = 0;

    fx_restoring_divider_pipe #(.NI(NI), .NF(NF)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef DIVIDER_SIGNED_EN
        .in_signed (in_signed),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division of the scaled dividend, saturated when signed.
    task automatic model(input logic [NI-1:0] x, input logic [NI-1:0] d, input bit sg,
                         output logic [QW-1:0] eq, output logic [NI-1:0] er,
                         output logic ez, output logic eo);
        longint num, den, qt, rm;
        ez = 1'b0;
        eo = 1'b0;
        if (d == 0) begin
            eq = '1;
            er = x;
            ez = 1'b1;
        end else begin
            num = sg ? longint'($signed(x)) : longint'(x);
            den = sg ? longint'($signed(d)) : longint'(d);
            num = num * (longint'(1) << NF);
            qt  = num / den;
            rm  = num - qt * den;
            er  = rm[NI-1:0];
            if (sg && qt > 32767) begin
                eq = 16'h7FFF; eo = 1'b1;
            end else if (sg && qt < -32768) begin
                eq = 16'h8000; eo = 1'b1;
            end else begin
                eq = qt[QW-1:0];
            end
        end
    endtask

    task automatic run_op(input logic [NI-1:0] x, input logic [NI-1:0] d, input bit sg, input int hold);
        logic [QW-1:0] eq;
        logic [NI-1:0] er;
        logic ez, eo;
        int cyc;
        model(x, d, sg, eq, er, ez, eo);
        @(negedge clk);
        dividend = x; divisor = d; in_signed = sg; in_valid = 1'b1;
        chk("in_ready_idle", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", cyc, (d == 0) ? 1 : (sg ? QW + 2 : QW + 1));
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_zero", div_zero, ez);
        chk("ovf", ovf, eo);
        chk("in_ready_done", in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_quotient", quotient, eq);
            chk("hold_remainder", remainder, er);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_drop", out_valid, 0);
        chk("back_idle", in_ready, 1);
        chk("kept_quotient", quotient, eq);
    endtask

    initial begin
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_div_zero", div_zero, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        reset_n = 1'b1;

        run_op(8'd7, 8'd2, 0, 0);
        chk("x7_d2_const", quotient, 16'h0380);
        run_op(8'd1, 8'd3, 0, 0);
        chk("x1_d3_const", quotient, 16'h0055);
        run_op(8'd9, 8'd0, 0, 0);
        chk("dz_const", quotient, 16'hFFFF);
        run_op(8'd200, 8'd7, 0, 5);
        run_op(8'd255, 8'd1, 0, 1);
        run_op(8'd0, 8'd5, 0, 0);
        run_op(8'd1, 8'd255, 0, 0);
        run_op(8'd255, 8'd255, 0, 0);

        // Reset in the middle of a calculation.
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_remainder", remainder, 0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op(8'd100, 8'd3, 0, 0);

        for (int i = 0; i < 20; i++) begin
            logic [NI-1:0] rx, rd;
            rx = NI'($urandom);
            rd = ($urandom_range(0, 7) == 0) ? '0 : NI'($urandom);
            run_op(rx, rd, 0, $urandom_range(0, 3));
        end

`ifdef DIVIDER_SIGNED_EN
        run_op(8'hF9, 8'd2, 1, 0);
        chk("sgn_m7_d2_const", quotient, 16'hFC80);
        run_op(8'h80, 8'hFF, 1, 0);
        chk("sgn_sat_const", quotient, 16'h7FFF);
        run_op(8'd5, 8'h01, 1, 0);
        run_op(8'h81, 8'h01, 1, 0);
        for (int i = 0; i < 12; i++) begin
            logic [NI-1:0] sx, sd;
            sx = NI'($urandom);
            sd = NI'($urandom);
            run_op(sx, sd, 1, $urandom_range(0, 2));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
